vtg_gen: RTL and testbench
==========================

# vtg_gen

Video timing generator. It produces the horizontal sync, vertical sync, data enable and frame-start signals for a video output path, plus pixel coordinates for the frame-buffer read side. It is the source end of the VS-based frame-start link: its O_vs feeds a downstream frame-start capture stage, and its O_fs paces the frame-buffer reader directly.

## Interface
Parameters:
- H_ACT, 1920: active pixels per line
- H_FP, 88: horizontal front porch, in pixels
- H_SYNC, 44: horizontal sync width, in pixels
- H_BP, 148: horizontal back porch, in pixels
- V_ACT, 1080: active lines per frame
- V_FP, 4: vertical front porch, in lines
- V_SYNC, 5: vertical sync width, in lines
- V_BP, 36: vertical back porch, in lines
- HS_POL, 1: asserted level of O_hs
- VS_POL, 1: asserted level of O_vs

Ports:
- I_clk, input, 1: pixel clock
- I_rst, input, 1: reset, asynchronous, active-high
- I_en, input, 1: timing run enable
- I_fs_ext, input, 1: external frame lock request, synchronous to I_clk; present only with VTG_FRAME_LOCK_EN
- O_hs, output, 1: horizontal sync
- O_vs, output, 1: vertical sync
- O_de, output, 1: active video
- O_fs, output, 1: frame-start pulse, one cycle wide
- O_x, output, 12: active pixel column
- O_y, output, 12: active line row

## Operation
Widths and totals:
- H_TOT = H_ACT+H_FP+H_SYNC+H_BP; V_TOT is formed the same way.
- Both totals must be ≤ 4096. Counters are 12 bits wide.

Counters:
- h_cnt runs 0..H_TOT-1 and wraps to 0.
- v_cnt increments when h_cnt wraps. It runs 0..V_TOT-1 and wraps to 0.

Region order within a line and within a frame: active, then front porch, then sync, then back porch.
- de_c = (h_cnt < H_ACT) && (v_cnt < V_ACT)
- hs_c = h_cnt in [H_ACT+H_FP, H_ACT+H_FP+H_SYNC)
- vs_c = v_cnt in [V_ACT+V_FP, V_ACT+V_FP+V_SYNC). vs_c therefore changes only when h_cnt == 0.
- fs_c = (h_cnt == 0) && (v_cnt == 0)

Output stage:
- All outputs are registered from the combinational terms above.
- O_hs = hs_c ? HS_POL : !HS_POL. O_vs follows the same rule with VS_POL.
- O_x = h_cnt and O_y = v_cnt when de_c is true. Otherwise O_x and O_y are 0.

Enable:
- While I_en is low: counters are held at 0, O_de = 0, O_fs = 0, and O_hs/O_vs sit at their deasserted levels.
- On the first cycle I_en is high, counting starts from (0,0). O_fs fires on the next cycle.

Reset:
- Reset forces counters to 0, O_de = 0, O_fs = 0, O_x = O_y = 0, O_hs = !HS_POL and O_vs = !VS_POL.
- A reset asserted mid-frame aborts the frame immediately. No partial-frame completion.

State: the block has two states, IDLE (I_en low) and RUN.
- IDLE → RUN on I_en = 1.
- RUN → IDLE on I_en = 0, taking effect the next cycle.

## Timing
- Latency from counter value to outputs is 1 cycle.
- O_fs and the first O_de of a frame are asserted in the same cycle, with O_x = O_y = 0.
- Each frame is exactly H_TOT×V_TOT cycles. O_fs is asserted once per frame.
- The O_vs leading edge occurs (V_ACT+V_FP)×H_TOT cycles after O_fs.

## Configuration
Macro: VTG_FRAME_LOCK_EN.

When defined:
- I_fs_ext exists and is edge-detected by a registered compare of the current and previous sample.
- A rising edge forces h_cnt = v_cnt = 0 on the following cycle. O_fs fires one cycle after that.
- If the edge arrives while the counters are already at (0,0), the edge is ignored, so no double O_fs occurs.
- Edges are ignored while I_en is low.
- An edge that coincides with a natural wrap produces a single frame start.

When undefined:
- The port is absent and the block free-runs.

## Structure
- Package vtg_pkg: localparams for standard modes (720p60, 1080p60, with all 8 values each), the counter width constant (12), and a typedef for the region state.
- One sub-module, vtg_edge_det, provides the rising-edge detector used for I_fs_ext. It is instantiated only under the macro.

## Test plan
1. Small mode: H_ACT=8, H_FP=2, H_SYNC=2, H_BP=2, V_ACT=4, V_FP=1, V_SYNC=1, V_BP=1, so H_TOT=14 and V_TOT=7. Release reset, set I_en=1 → O_fs is seen every 98 cycles, O_de is high 8 cycles per line on 4 lines, and O_hs is high at h_cnt 10–11.
2. Same mode → O_vs is high for exactly 14 cycles starting 70 cycles after O_fs. With VS_POL=0 the polarity is inverted.
3. Assert I_rst in the middle of line 2 → outputs go to reset values immediately. After release with I_en=1, O_fs appears on the second cycle.
4. Drop I_en for 20 cycles mid-frame → outputs stay idle. On re-enable, a fresh frame starts at O_x = O_y = 0.
5. With VTG_FRAME_LOCK_EN, pulse I_fs_ext at h_cnt=5, v_cnt=2 → the counters restart and O_fs appears 2 cycles after the edge. An edge applied at (0,0) produces no extra O_fs.
6. Check O_x/O_y across a full frame → they sweep 0..7 and 0..3 during O_de and are 0 otherwise.

Source files
------------

// File: rtl/vtg_pkg.sv
// vtg_pkg: shared constants and types for the video timing generator.
// Holds standard mode timings, the counter width and the region/state types.
package vtg_pkg;

  // Counter width; both horizontal and vertical totals must fit in 2**CNT_W
  localparam int CNT_W = 12;
  localparam int EXT_W = CNT_W + 1;

  // 1280x720 @ 60 Hz (74.25 MHz pixel clock)
  localparam int M720P60_H_ACT  = 1280;
  localparam int M720P60_H_FP   = 110;
  localparam int M720P60_H_SYNC = 40;
  localparam int M720P60_H_BP   = 220;
  localparam int M720P60_V_ACT  = 720;
  localparam int M720P60_V_FP   = 5;
  localparam int M720P60_V_SYNC = 5;
  localparam int M720P60_V_BP   = 20;

  // 1920x1080 @ 60 Hz (148.5 MHz pixel clock)
  localparam int M1080P60_H_ACT  = 1920;
  localparam int M1080P60_H_FP   = 88;
  localparam int M1080P60_H_SYNC = 44;
  localparam int M1080P60_H_BP   = 148;
  localparam int M1080P60_V_ACT  = 1080;
  localparam int M1080P60_V_FP   = 4;
  localparam int M1080P60_V_SYNC = 5;
  localparam int M1080P60_V_BP   = 36;

  // Region of a line or a frame, in the order they occur
  typedef enum logic [1:0] {
    RG_ACTIVE = 2'd0,
    RG_FP     = 2'd1,
    RG_SYNC   = 2'd2,
    RG_BP     = 2'd3
  } region_t;

  // Run state of the generator
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Classify a counter position given the start of each later region.
  // Positions are one bit wider so a region boundary equal to 2**CNT_W works.
  function automatic region_t region_of(input logic [EXT_W-1:0] pos,
                                        input logic [EXT_W-1:0] fp_start,
                                        input logic [EXT_W-1:0] sync_start,
                                        input logic [EXT_W-1:0] bp_start);
    region_t r;
    if (pos < fp_start)        r = RG_ACTIVE;
    else if (pos < sync_start) r = RG_FP;
    else if (pos < bp_start)   r = RG_SYNC;
    else                       r = RG_BP;
    return r;
  endfunction

endpackage

// File: rtl/vtg_edge_det.sv
// vtg_edge_det: rising-edge detector for the external frame lock request.
// Compares the live input with its previous registered sample.
module vtg_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic prev;

  // Remember the previous sample of the input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= 1'b0;
    else     prev <= din;
  end

  assign rise = din & ~prev;

endmodule

// File: rtl/vtg_gen.sv
// vtg_gen: video timing generator producing hsync, vsync, data enable,
// a one-cycle frame-start pulse and active pixel coordinates.
// Optional feature macro: VTG_FRAME_LOCK_EN adds I_fs_ext, whose rising edge
// restarts the frame at (0,0).
module vtg_gen
  import vtg_pkg::*;
#(
  parameter int H_ACT  = 1920,
  parameter int H_FP   = 88,
  parameter int H_SYNC = 44,
  parameter int H_BP   = 148,
  parameter int V_ACT  = 1080,
  parameter int V_FP   = 4,
  parameter int V_SYNC = 5,
  parameter int V_BP   = 36,
  parameter int HS_POL = 1,
  parameter int VS_POL = 1
) (
  input  logic             I_clk,
  input  logic             I_rst,
  input  logic             I_en,
`ifdef VTG_FRAME_LOCK_EN
  input  logic             I_fs_ext,
`endif
  output logic             O_hs,
  output logic             O_vs,
  output logic             O_de,
  output logic             O_fs,
  output logic [CNT_W-1:0] O_x,
  output logic [CNT_W-1:0] O_y
);

  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOT - 1);

  localparam logic [EXT_W-1:0] H_FP_START   = EXT_W'(H_ACT);
  localparam logic [EXT_W-1:0] H_SYNC_START = EXT_W'(H_ACT + H_FP);
  localparam logic [EXT_W-1:0] H_BP_START   = EXT_W'(H_ACT + H_FP + H_SYNC);
  localparam logic [EXT_W-1:0] V_FP_START   = EXT_W'(V_ACT);
  localparam logic [EXT_W-1:0] V_SYNC_START = EXT_W'(V_ACT + V_FP);
  localparam logic [EXT_W-1:0] V_BP_START   = EXT_W'(V_ACT + V_FP + V_SYNC);

  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  state_t           state;
  state_t           state_next;
  logic             run;
  logic             lock;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic [CNT_W-1:0] h_next;
  logic [CNT_W-1:0] v_next;
  region_t          h_region;
  region_t          v_region;
  logic             de_c;
  logic             hs_c;
  logic             vs_c;
  logic             fs_c;

  // FSM state register
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) state <= ST_IDLE;
    else       state <= state_next;
  end

  // FSM next state: the enable input alone selects IDLE or RUN
  always_comb begin
    state_next = ST_IDLE;
    case (state)
      ST_IDLE: state_next = I_en ? ST_RUN : ST_IDLE;
      ST_RUN:  state_next = I_en ? ST_RUN : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM output: the counters advance and outputs are live whenever the
  // machine is (or is entering) RUN, so the first enabled cycle counts (0,0)
  always_comb begin
    run = 1'b0;
    if (state_next == ST_RUN) run = 1'b1;
  end

`ifdef VTG_FRAME_LOCK_EN
  logic fs_rise;

  vtg_edge_det u_edge_det (
    .clk  (I_clk),
    .rst  (I_rst),
    .din  (I_fs_ext),
    .rise (fs_rise)
  );

  // A restart while already at (0,0) would duplicate the frame start
  assign lock = fs_rise && run && ((h_cnt != '0) || (v_cnt != '0));
`else
  assign lock = 1'b0;
`endif

  // Next counter values: hold at origin when idle or locking, else raster scan
  always_comb begin
    h_next = '0;
    v_next = '0;
    if (run && !lock) begin
      if (h_cnt == H_LAST) begin
        h_next = '0;
        v_next = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_next = h_cnt + 1'b1;
        v_next = v_cnt;
      end
    end
  end

  // Pixel and line counters
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_next;
      v_cnt <= v_next;
    end
  end

  // Decode the current position into line/frame regions
  always_comb begin
    h_region = region_of({1'b0, h_cnt}, H_FP_START, H_SYNC_START, H_BP_START);
    v_region = region_of({1'b0, v_cnt}, V_FP_START, V_SYNC_START, V_BP_START);
    de_c     = (h_region == RG_ACTIVE) && (v_region == RG_ACTIVE);
    hs_c     = (h_region == RG_SYNC);
    vs_c     = (v_region == RG_SYNC);
    fs_c     = (h_cnt == '0) && (v_cnt == '0);
  end

  // Registered output stage, one cycle behind the counters
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      O_hs <= ~HS_ON;
      O_vs <= ~VS_ON;
      O_de <= 1'b0;
      O_fs <= 1'b0;
      O_x  <= '0;
      O_y  <= '0;
    end else if (!run) begin
      O_hs <= ~HS_ON;
      O_vs <= ~VS_ON;
      O_de <= 1'b0;
      O_fs <= 1'b0;
      O_x  <= '0;
      O_y  <= '0;
    end else begin
      O_hs <= hs_c ? HS_ON : ~HS_ON;
      O_vs <= vs_c ? VS_ON : ~VS_ON;
      O_de <= de_c;
      O_fs <= fs_c;
      O_x  <= de_c ? h_cnt : '0;
      O_y  <= de_c ? v_cnt : '0;
    end
  end

endmodule

// File: tb/tb_vtg_gen.sv
// tb_vtg_gen: randomized self-checking bench for vtg_gen in a small 14x7 mode.
// The reference model tracks a single linear frame position and derives every
// output from it arithmetically.
module tb_vtg_gen;

  localparam int HA = 8, HF = 2, HSW = 2, HB = 2;
  localparam int VA = 4, VF = 1, VSW = 1, VB = 1;
  localparam int HT = HA + HF + HSW + HB;   // 14
  localparam int VT = VA + VF + VSW + VB;   // 7
  localparam int FR = HT * VT;              // 98
  localparam int HSP = 1;
  localparam int VSP = 0;
`ifdef VTG_FRAME_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        en;
  logic        fs_ext;
  logic        o_hs, o_vs, o_de, o_fs;
  logic [11:0] o_x, o_y;

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;
  int cyc = 0;

  vtg_gen #(
    .H_ACT(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACT(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(HSP), .VS_POL(VSP)
  ) dut (
    .I_clk    (clk),
    .I_rst    (rst),
    .I_en     (en),
`ifdef VTG_FRAME_LOCK_EN
    .I_fs_ext (fs_ext),
`endif
    .O_hs     (o_hs),
    .O_vs     (o_vs),
    .O_de     (o_de),
    .O_fs     (o_fs),
    .O_x      (o_x),
    .O_y      (o_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit m_de(input int p);
    return ((p % HT) < HA) && ((p / HT) < VA);
  endfunction
  function automatic bit m_hs(input int p);
    int h;
    h = p % HT;
    return ((h >= HA + HF) && (h < HA + HF + HSW)) ? HSP[0] : !HSP[0];
  endfunction
  function automatic bit m_vs(input int p);
    int v;
    v = p / HT;
    return ((v >= VA + VF) && (v < VA + VF + VSW)) ? VSP[0] : !VSP[0];
  endfunction

  int          pos;
  bit          prev_ext;
  logic        e_hs, e_vs, e_de, e_fs;
  logic [11:0] e_x, e_y;

  // Model: pos is the frame position the counters hold this cycle
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pos <= 0; prev_ext <= 1'b0;
      e_hs <= !HSP[0]; e_vs <= !VSP[0]; e_de <= 1'b0; e_fs <= 1'b0;
      e_x <= '0; e_y <= '0;
    end else begin
      prev_ext <= fs_ext;
      if (!en) begin
        pos <= 0;
        e_hs <= !HSP[0]; e_vs <= !VSP[0]; e_de <= 1'b0; e_fs <= 1'b0;
        e_x <= '0; e_y <= '0;
      end else begin
        e_hs <= m_hs(pos);
        e_vs <= m_vs(pos);
        e_de <= m_de(pos);
        e_fs <= (pos == 0);
        e_x  <= m_de(pos) ? 12'(pos % HT) : 12'd0;
        e_y  <= m_de(pos) ? 12'(pos / HT) : 12'd0;
        if (LOCK && fs_ext && !prev_ext && pos != 0) pos <= 0;
        else                                         pos <= (pos + 1) % FR;
      end
    end
  end

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (chk_on) begin
      vectors <= vectors + 1;
      if ({o_hs, o_vs, o_de, o_fs, o_x, o_y} !== {e_hs, e_vs, e_de, e_fs, e_x, e_y}) begin
        miscompares <= miscompares + 1;
        $display("FAIL model cyc %0d: got hs=%b vs=%b de=%b fs=%b x=%0d y=%0d, want hs=%b vs=%b de=%b fs=%b x=%0d y=%0d",
                 cyc, o_hs, o_vs, o_de, o_fs, o_x, o_y, e_hs, e_vs, e_de, e_fs, e_x, e_y);
      end
    end
  end

  // ---------------- literal checks ----------------
  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end else begin
      $display("check %s: %0d", name, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for O_fs at a negedge; returns 1 if seen
  task automatic wait_fs(output bit got);
    got = 1'b0;
    for (int i = 0; i < 3 * FR && !got; i++) begin
      @(negedge clk);
      if (o_fs) got = 1'b1;
    end
    check("fs_wait", int'(got), 1);
  endtask

  // Measure one undisturbed frame starting at an O_fs
  task automatic frame_stats();
    bit got;
    int de_n, hs_n, vs_n, vs_first, gap, xmax, ymax;
    de_n = 0; hs_n = 0; vs_n = 0; vs_first = -1; gap = -1; xmax = 0; ymax = 0;
    wait_fs(got);
    check("fs_first_de", int'(o_de), 1);
    check("fs_first_xy", int'(o_x) + int'(o_y), 0);
    for (int t = 0; t <= FR; t++) begin
      if (t > 0) @(negedge clk);
      if (t > 0 && o_fs && gap < 0) gap = t;
      if (t < FR) begin
        de_n += int'(o_de);
        hs_n += int'(o_hs == HSP[0]);
        if (o_vs == VSP[0]) begin
          vs_n++;
          if (vs_first < 0) vs_first = t;
        end
        if (o_de) begin
          if (int'(o_x) > xmax) xmax = int'(o_x);
          if (int'(o_y) > ymax) ymax = int'(o_y);
        end
      end
    end
    check("fs_period", gap, 98);
    check("de_per_frame", de_n, 32);
    check("hs_per_frame", hs_n, 14);
    check("vs_width", vs_n, 14);
    check("vs_offset", vs_first, 70);
    check("x_max", xmax, 7);
    check("y_max", ymax, 3);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit got;
    int en_hold, rst_hold;
    rst = 1'b1; en = 1'b0; fs_ext = 1'b0;
    step(3);
    chk_on = 1'b1;
    check("rst_hs", int'(o_hs), 0);
    check("rst_vs", int'(o_vs), 1);
    check("rst_de_fs", int'(o_de) + int'(o_fs), 0);

    // Release reset with enable low: idle
    rst = 1'b0;
    step(4);
    check("idle_fs", int'(o_fs), 0);

    // Enable: O_fs on the cycle after the first enabled edge
    en = 1'b1;
    @(negedge clk);
    check("en_fs_early", int'(o_fs), 0);
    @(negedge clk);
    check("en_fs", int'(o_fs), 1);

    // Full frame measurements
    frame_stats();

    // Mid-frame reset in line 2: immediate, then fresh frame
    wait_fs(got);
    step(30);
    rst = 1'b1;
    #1;
    check("async_rst_vs", int'(o_vs), 1);
    check("async_rst_de", int'(o_de), 0);
    check("async_rst_xy", int'(o_x) + int'(o_y), 0);
    step(2);
    rst = 1'b0;
    @(negedge clk);
    check("rst_rel_fs_c1", int'(o_fs), 0);
    @(negedge clk);
    check("rst_rel_fs_c2", int'(o_fs), 1);

    // Enable drop for 20 cycles mid-frame
    step(40);
    en = 1'b0;
    step(20);
    check("drop_de", int'(o_de), 0);
    check("drop_hs", int'(o_hs), 0);
    en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reen_fs", int'(o_fs), 1);
    check("reen_xy", int'(o_x) + int'(o_y), 0);

`ifdef VTG_FRAME_LOCK_EN
    // Lock pulse while counters sit at h=5, v=2 (position 33)
    wait_fs(got);
    repeat (32) @(posedge clk);
    #1 fs_ext = 1'b1;
    @(posedge clk);
    #1 fs_ext = 1'b0;
    @(negedge clk);
    check("lock_fs_c1", int'(o_fs), 0);
    @(negedge clk);
    check("lock_fs_c2", int'(o_fs), 1);
    // Edge sampled while counters are at (0,0): single frame start
    repeat (FR - 1) @(posedge clk);
    #1 fs_ext = 1'b1;
    step(3);
    fs_ext = 1'b0;
    frame_stats();
`endif

    // Randomized phase: enable drops, resets, lock pulses
    en_hold = 0; rst_hold = 0;
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(0, 999));
      if (rst_hold > 0) rst_hold--;
      else if (r < 2) rst_hold = int'($urandom_range(1, 3));
      if (en_hold > 0) en_hold--;
      else if (r >= 2 && r < 6) en_hold = int'($urandom_range(1, 25));
      rst = (rst_hold > 0);
      en  = (en_hold == 0);
      fs_ext = LOCK ? ($urandom_range(0, 99) < 3) : 1'b0;
      step(1);
    end
    rst = 1'b0; en = 1'b1; fs_ext = 1'b0;
    step(2);
    frame_stats();

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
